// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter that shares one register-bus target among NumReq requesters.
// Define REG_RR_ARBITER_TIMEOUT_EN to end stalled transfers after TimeoutCycles with an error response.
module reg_rr_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256,
    localparam int unsigned StrbWidth    = DataWidth / 8,
    localparam int unsigned IdxW         = $clog2(NumReq)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumReq-1:0]              req_valid_i,
    input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0]              req_write_i,
    input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq*StrbWidth-1:0]    req_wstrb_i,
    output logic [NumReq-1:0]              rsp_ready_o,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           rsp_error_o,
    output logic                           tgt_valid_o,
    output logic [AddrWidth-1:0]           tgt_addr_o,
    output logic                           tgt_write_o,
    output logic [DataWidth-1:0]           tgt_wdata_o,
    output logic [StrbWidth-1:0]           tgt_wstrb_o,
    input  logic                           tgt_ready_i,
    input  logic [DataWidth-1:0]           tgt_rdata_i,
    input  logic                           tgt_error_i,
    output logic [IdxW-1:0]                grant_idx_o,
    output logic                           busy_o
);

    if (NumReq < 2 || NumReq > 16 || TimeoutCycles < 2) begin : g_param_check
        $error("reg_rr_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e          state_q;
    logic [IdxW-1:0] grant_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] ptr_d;
    logic [IdxW-1:0] arb_idx;
    logic [IdxW-1:0] cand;
    logic            arb_found;
    logic            busy;
    logic            owner_valid;
    logic            complete;
    logic            abort;
    logic            timeout;

    // First valid requester at or after the priority pointer, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(ptr_q) + i) % NumReq);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign ptr_d       = (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
    assign busy        = (state_q == BUSY) && !rst_i;
    assign owner_valid = req_valid_i[grant_q];
    assign complete    = busy && owner_valid && tgt_ready_i;
    assign abort       = busy && !owner_valid;

`ifdef REG_RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles);
    logic [CntW-1:0] cnt_q;

    // Ready on the final cycle wins, so timeout requires ready low.
    assign timeout = busy && owner_valid && !tgt_ready_i
                     && (cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (!tgt_ready_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        grant_q <= arb_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (complete || abort || timeout) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tgt_valid_o = busy && owner_valid && !timeout;
    assign tgt_addr_o  = req_addr_i[grant_q*AddrWidth +: AddrWidth];
    assign tgt_write_o = req_write_i[grant_q];
    assign tgt_wdata_o = req_wdata_i[grant_q*DataWidth +: DataWidth];
    assign tgt_wstrb_o = req_wstrb_i[grant_q*StrbWidth +: StrbWidth];

    always_comb begin
        rsp_ready_o = '0;
        if (complete || timeout) begin
            rsp_ready_o[grant_q] = 1'b1;
        end
    end

    assign rsp_rdata_o = complete ? tgt_rdata_i : '0;
    assign rsp_error_o = complete ? tgt_error_i : timeout;
    assign grant_idx_o = grant_q;
    assign busy_o      = busy;

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed self-checking bench for reg_rr_arbiter (4 requesters, TimeoutCycles=8).
module tb_reg_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N-1:0]      req_write_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N*SW-1:0]   req_wstrb_i;
    logic [N-1:0]      rsp_ready_o;
    logic [DW-1:0]     rsp_rdata_o;
    logic              rsp_error_o;
    logic              tgt_valid_o;
    logic [AW-1:0]     tgt_addr_o;
    logic              tgt_write_o;
    logic [DW-1:0]     tgt_wdata_o;
    logic [SW-1:0]     tgt_wstrb_o;
    logic              tgt_ready_i;
    logic [DW-1:0]     tgt_rdata_i;
    logic              tgt_error_i;
    logic [1:0]        grant_idx_o;
    logic              busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_rr_arbiter #(
        .NumReq(N),
        .AddrWidth(AW),
        .DataWidth(DW),
        .TimeoutCycles(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_addr_i(req_addr_i),
        .req_write_i(req_write_i),
        .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .rsp_ready_o(rsp_ready_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_error_o(rsp_error_o),
        .tgt_valid_o(tgt_valid_o),
        .tgt_addr_o(tgt_addr_o),
        .tgt_write_o(tgt_write_o),
        .tgt_wdata_o(tgt_wdata_o),
        .tgt_wstrb_o(tgt_wstrb_o),
        .tgt_ready_i(tgt_ready_i),
        .tgt_rdata_i(tgt_rdata_i),
        .tgt_error_i(tgt_error_i),
        .grant_idx_o(grant_idx_o),
        .busy_o(busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        tgt_ready_i = 1'b0;
        tgt_rdata_i = '0;
        tgt_error_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        req_valid_i = 4'b1111;
        req_addr_i  = '0;
        req_write_i = '0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        tgt_ready_i = 1'b1;
        tgt_rdata_i = 32'hCAFE_F00D;
        tgt_error_i = 1'b1;
        tick();
        tick();
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy_o); end
        total++; if (tgt_valid_o !== 1'b0) begin bad++; $display("FAIL reset_tgt_valid got=%0h exp=0", tgt_valid_o); end
        total++; if (rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL reset_rsp_ready got=%0h exp=0", rsp_ready_o); end
        total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rsp_rdata_o); end
        total++; if (rsp_error_o !== 1'b0) begin bad++; $display("FAIL reset_error got=%0h exp=0", rsp_error_o); end
        total++; if (grant_idx_o !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant_idx_o); end
        rst_i       = 1'b0;
        req_valid_i = '0;
        tgt_ready_i = 1'b0;
        tgt_rdata_i = '0;
        tgt_error_i = 1'b0;
        tick();
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_no_valid got=%0h exp=0", busy_o); end
    endtask

    task automatic test_single();
        req_valid_i           = 4'b0100;
        req_addr_i[2*AW +: AW] = 48'h1000;
        req_write_i[2]        = 1'b1;
        req_wdata_i[2*DW +: DW] = 32'hDEAD_BEEF;
        req_wstrb_i[2*SW +: SW] = 4'hF;
        tgt_ready_i           = 1'b0;
        #1;
        total++; if (tgt_valid_o !== 1'b0) begin bad++; $display("FAIL single_arb_tgt_valid got=%0h exp=0", tgt_valid_o); end
        tick();
        #1;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy got=%0h exp=1", busy_o); end
        total++; if (grant_idx_o !== 2'd2) begin bad++; $display("FAIL single_grant got=%0d exp=2", grant_idx_o); end
        total++; if (tgt_valid_o !== 1'b1) begin bad++; $display("FAIL single_tgt_valid got=%0h exp=1", tgt_valid_o); end
        total++; if (tgt_addr_o !== 48'h1000) begin bad++; $display("FAIL single_addr got=%0h exp=1000", tgt_addr_o); end
        total++; if (tgt_write_o !== 1'b1) begin bad++; $display("FAIL single_write got=%0h exp=1", tgt_write_o); end
        total++; if (tgt_wdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wdata got=%0h exp=deadbeef", tgt_wdata_o); end
        total++; if (tgt_wstrb_o !== 4'hF) begin bad++; $display("FAIL single_wstrb got=%0h exp=f", tgt_wstrb_o); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL single_wait_rsp got=%0h exp=0 cyc=%0d", rsp_ready_o, i); end
            tick();
        end
        tgt_ready_i = 1'b1;
        #1;
        total++; if (rsp_ready_o !== 4'b0100) begin bad++; $display("FAIL single_rsp got=%0h exp=4", rsp_ready_o); end
        total++; if (rsp_error_o !== 1'b0) begin bad++; $display("FAIL single_err got=%0h exp=0", rsp_error_o); end
        tick();
        tgt_ready_i = 1'b0;
        req_valid_i = '0;
        #1;
        total++; if (rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL single_pulse_end got=%0h exp=0", rsp_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL single_idle got=%0h exp=0", busy_o); end
    endtask

    task automatic test_error_read();
        req_valid_i             = 4'b0010;
        req_write_i[1]          = 1'b0;
        req_addr_i[1*AW +: AW]  = 48'h2000;
        #1;
        tick();
        tgt_ready_i = 1'b1;
        tgt_rdata_i = 32'h1234_5678;
        tgt_error_i = 1'b1;
        #1;
        total++; if (grant_idx_o !== 2'd1) begin bad++; $display("FAIL err_grant got=%0d exp=1", grant_idx_o); end
        total++; if (tgt_write_o !== 1'b0) begin bad++; $display("FAIL err_write got=%0h exp=0", tgt_write_o); end
        total++; if (rsp_ready_o !== 4'b0010) begin bad++; $display("FAIL err_rsp got=%0h exp=2", rsp_ready_o); end
        total++; if (rsp_rdata_o !== 32'h1234_5678) begin bad++; $display("FAIL err_rdata got=%0h exp=12345678", rsp_rdata_o); end
        total++; if (rsp_error_o !== 1'b1) begin bad++; $display("FAIL err_error got=%0h exp=1", rsp_error_o); end
        tick();
        tgt_ready_i = 1'b0;
        req_valid_i = '0;
        #1;
        total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL err_rdata_gated got=%0h exp=0", rsp_rdata_o); end
        total++; if (rsp_error_o !== 1'b0) begin bad++; $display("FAIL err_error_gated got=%0h exp=0", rsp_error_o); end
        tgt_rdata_i = '0;
        tgt_error_i = 1'b0;
    endtask

    task automatic test_fairness();
        logic [1:0] g;
        logic [3:0] onehot;
        do_reset();
        req_valid_i = 4'b1111;
        tgt_ready_i = 1'b1;
        for (int n = 0; n < 5; n++) begin
            g      = 2'(n % 4);
            onehot = 4'b0001 << g;
            #1;
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL fair_gap busy got=%0h exp=0 n=%0d", busy_o, n); end
            tick();
            #1;
            total++; if (grant_idx_o !== g) begin bad++; $display("FAIL fair_grant got=%0d exp=%0d", grant_idx_o, g); end
            total++; if (rsp_ready_o !== onehot) begin bad++; $display("FAIL fair_rsp got=%0h exp=%0h", rsp_ready_o, onehot); end
            tick();
        end
        req_valid_i = '0;
        tgt_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        req_valid_i = 4'b0100;
        tgt_ready_i = 1'b1;
        #1;
        tick();
        #1;
        total++; if (rsp_ready_o !== 4'b0100) begin bad++; $display("FAIL wrap_setup got=%0h exp=4", rsp_ready_o); end
        tick();
        req_valid_i = 4'b1001;
        #1;
        tick();
        #1;
        total++; if (grant_idx_o !== 2'd3) begin bad++; $display("FAIL wrap_first got=%0d exp=3", grant_idx_o); end
        total++; if (rsp_ready_o !== 4'b1000) begin bad++; $display("FAIL wrap_first_rsp got=%0h exp=8", rsp_ready_o); end
        tick();
        tick();
        #1;
        total++; if (grant_idx_o !== 2'd0) begin bad++; $display("FAIL wrap_second got=%0d exp=0", grant_idx_o); end
        total++; if (rsp_ready_o !== 4'b0001) begin bad++; $display("FAIL wrap_second_rsp got=%0h exp=1", rsp_ready_o); end
        tick();
        req_valid_i = '0;
        tgt_ready_i = 1'b0;
    endtask

    task automatic test_abort();
        req_valid_i = 4'b0010;
        #1;
        tick();
        req_valid_i = 4'b1010;
        #1;
        total++; if (grant_idx_o !== 2'd1) begin bad++; $display("FAIL abort_hold_grant got=%0d exp=1", grant_idx_o); end
        total++; if (tgt_valid_o !== 1'b1) begin bad++; $display("FAIL abort_hold_valid got=%0h exp=1", tgt_valid_o); end
        tick();
        req_valid_i = 4'b1000;
        #1;
        total++; if (tgt_valid_o !== 1'b0) begin bad++; $display("FAIL abort_tgt_valid got=%0h exp=0", tgt_valid_o); end
        total++; if (rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL abort_rsp got=%0h exp=0", rsp_ready_o); end
        tick();
        req_valid_i = 4'b1010;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0h exp=0", busy_o); end
        tick();
        #1;
        total++; if (grant_idx_o !== 2'd3) begin bad++; $display("FAIL abort_next_grant got=%0d exp=3", grant_idx_o); end
        tgt_ready_i = 1'b1;
        #1;
        total++; if (rsp_ready_o !== 4'b1000) begin bad++; $display("FAIL abort_next_rsp got=%0h exp=8", rsp_ready_o); end
        tick();
        req_valid_i = '0;
        tgt_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_busy();
        req_valid_i = 4'b0010;
        #1;
        tick();
        #1;
        total++; if (grant_idx_o !== 2'd1) begin bad++; $display("FAIL rstbusy_grant got=%0d exp=1", grant_idx_o); end
        rst_i       = 1'b1;
        tgt_ready_i = 1'b1;
        #1;
        total++; if (rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL rstbusy_rsp got=%0h exp=0", rsp_ready_o); end
        total++; if (tgt_valid_o !== 1'b0) begin bad++; $display("FAIL rstbusy_tgt_valid got=%0h exp=0", tgt_valid_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstbusy_busy got=%0h exp=0", busy_o); end
        tick();
        rst_i       = 1'b0;
        tgt_ready_i = 1'b0;
        req_valid_i = 4'b0101;
        #1;
        total++; if (grant_idx_o !== 2'd0) begin bad++; $display("FAIL rstbusy_grant_clr got=%0d exp=0", grant_idx_o); end
        tick();
        #1;
        total++; if (grant_idx_o !== 2'd0) begin bad++; $display("FAIL rstbusy_next_grant got=%0d exp=0", grant_idx_o); end
        tgt_ready_i = 1'b1;
        #1;
        total++; if (rsp_ready_o !== 4'b0001) begin bad++; $display("FAIL rstbusy_next_rsp got=%0h exp=1", rsp_ready_o); end
        tick();
        req_valid_i = '0;
        tgt_ready_i = 1'b0;
    endtask

    task automatic test_timeout();
        req_valid_i = 4'b0010;
        tgt_rdata_i = 32'hAAAA_5555;
        #1;
        tick();
`ifdef REG_RR_ARBITER_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            #1;
            total++; if (rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL tmo_early got=%0h exp=0 cyc=%0d", rsp_ready_o, k); end
            tick();
        end
        #1;
        total++; if (rsp_ready_o !== 4'b0010) begin bad++; $display("FAIL tmo_rsp got=%0h exp=2", rsp_ready_o); end
        total++; if (rsp_error_o !== 1'b1) begin bad++; $display("FAIL tmo_err got=%0h exp=1", rsp_error_o); end
        total++; if (rsp_rdata_o !== 32'h0) begin bad++; $display("FAIL tmo_rdata got=%0h exp=0", rsp_rdata_o); end
        total++; if (tgt_valid_o !== 1'b0) begin bad++; $display("FAIL tmo_tgt_valid got=%0h exp=0", tgt_valid_o); end
        tick();
        req_valid_i = '0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%0h exp=0", busy_o); end
`else
        for (int k = 0; k < 20; k++) begin
            #1;
            total++; if (busy_o !== 1'b1 || rsp_ready_o !== 4'b0000) begin bad++; $display("FAIL notmo_wait busy=%0h rsp=%0h exp busy=1 rsp=0 cyc=%0d", busy_o, rsp_ready_o, k); end
            tick();
        end
        req_valid_i = '0;
        #1;
        total++; if (tgt_valid_o !== 1'b0) begin bad++; $display("FAIL notmo_abort got=%0h exp=0", tgt_valid_o); end
        tick();
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL notmo_idle got=%0h exp=0", busy_o); end
`endif
        tgt_rdata_i = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_error_read();
        test_fairness();
        test_wrap();
        test_abort();
        test_reset_mid_busy();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
